// File: rtl/tx_collision_ctrl.sv
// rtl/tx_collision_ctrl.sv - half-duplex CSMA/CD retry controller between the replay buffer and the TX MAC
// Sequences jam, replay, truncated binary exponential backoff and late/excessive-collision aborts.
module tx_collision_ctrl #(
  parameter int SLOT_CYCLES   = 64,
  parameter int JAM_CYCLES    = 4,
  parameter int MAX_ATTEMPTS  = 16,
  parameter int BACKOFF_LIMIT = 10,
  parameter int TAIL_CYCLES   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       half_duplex,
  input  logic       collision,
  input  logic       pkt_start,
  input  logic       pkt_end,
  input  logic       replayable,
  output logic       replay,
  output logic       done,
  output logic       tx_hold,
  output logic       jam,
  output logic       drop,
  output logic       abort_late,
  output logic       abort_excess,
  output logic [4:0] attempts
);

  localparam int CYC_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int JAM_W  = (JAM_CYCLES > 1) ? $clog2(JAM_CYCLES) : 1;
  localparam int TAIL_W = $clog2(TAIL_CYCLES + 1);

  localparam logic [4:0]        MAX_ATT   = 5'(MAX_ATTEMPTS);
  localparam logic [4:0]        BO_LIM    = 5'(BACKOFF_LIMIT);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(SLOT_CYCLES - 1);
  localparam logic [JAM_W-1:0]  JAM_LAST  = JAM_W'(JAM_CYCLES - 1);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_TAIL,
    S_JAM,
    S_BACKOFF,
    S_DROP
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        attempts_q, attempts_d;
  logic              late_q, late_d;
  logic [JAM_W-1:0]  jam_cnt_q, jam_cnt_d;
  logic [TAIL_W-1:0] tail_cnt_q, tail_cnt_d;
  logic [9:0]        slot_q, slot_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [15:0]       lfsr_q, lfsr_d;

  logic replay_q, replay_d;
  logic done_q, done_d;
  logic tx_hold_q, tx_hold_d;
  logic jam_q, jam_d;
  logic drop_q, drop_d;
  logic abort_late_q, abort_late_d;
  logic abort_excess_q, abort_excess_d;

  logic       col_hd;
  logic       enter_jam;
  logic       release_ok;
  logic [3:0] bo_k;
  logic [9:0] bo_mask;

  assign col_hd  = collision && half_duplex;
  assign bo_k    = (attempts_q > BO_LIM) ? BO_LIM[3:0] : attempts_q[3:0];
  assign bo_mask = (10'd1 << bo_k) - 10'd1;

  always_comb begin
    state_d        = state_q;
    attempts_d     = attempts_q;
    late_d         = late_q;
    jam_cnt_d      = jam_cnt_q;
    tail_cnt_d     = tail_cnt_q;
    slot_d         = slot_q;
    cyc_d          = cyc_q;
    replay_d       = 1'b0;
    done_d         = 1'b0;
    abort_late_d   = 1'b0;
    abort_excess_d = 1'b0;
    enter_jam      = 1'b0;
    release_ok     = 1'b0;
    lfsr_d         = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    case (state_q)
      S_IDLE: begin
        if (pkt_start) state_d = S_TX;
      end
      S_TX: begin
        if (col_hd) begin
          enter_jam = 1'b1;
        end else if (pkt_end) begin
          if (half_duplex) begin
            state_d    = S_TAIL;
            tail_cnt_d = TAIL_W'(1);
          end else begin
            release_ok = 1'b1;
          end
        end
      end
      S_TAIL: begin
        // A collision after the last beat is only retryable while the buffer still holds the frame.
        if (!replayable) begin
          release_ok = 1'b1;
        end else if (col_hd) begin
          enter_jam = 1'b1;
        end else if (tail_cnt_q >= TAIL_LAST) begin
          release_ok = 1'b1;
        end else begin
          tail_cnt_d = tail_cnt_q + TAIL_W'(1);
        end
      end
      S_JAM: begin
        if (jam_cnt_q == JAM_LAST) begin
          if (late_q) begin
            state_d      = S_DROP;
            late_d       = 1'b0;
            abort_late_d = 1'b1;
            done_d       = 1'b1;
          end else if (attempts_q == MAX_ATT) begin
            state_d        = S_DROP;
            abort_excess_d = 1'b1;
            done_d         = 1'b1;
          end else begin
            state_d = S_BACKOFF;
            slot_d  = lfsr_q[9:0] & bo_mask;
            cyc_d   = '0;
          end
        end else begin
          jam_cnt_d = jam_cnt_q + JAM_W'(1);
        end
      end
      S_BACKOFF: begin
        // A zero-slot draw still holds for one cycle before the retry.
        if (slot_q == 10'd0) begin
          state_d = S_IDLE;
        end else if (cyc_q == CYC_LAST) begin
          cyc_d  = '0;
          slot_d = slot_q - 10'd1;
          if (slot_q == 10'd1) state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DROP: begin
        if (pkt_end) begin
          state_d    = S_IDLE;
          attempts_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_jam) begin
      state_d    = S_JAM;
      jam_cnt_d  = '0;
      attempts_d = attempts_q + 5'd1;
      replay_d   = replayable;
      late_d     = !replayable;
    end
    if (release_ok) begin
      state_d    = S_IDLE;
      done_d     = 1'b1;
      attempts_d = '0;
    end

    jam_d     = (state_d == S_JAM);
    tx_hold_d = (state_d == S_JAM) || (state_d == S_BACKOFF);
    drop_d    = (state_d == S_DROP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      attempts_q     <= '0;
      late_q         <= 1'b0;
      jam_cnt_q      <= '0;
      tail_cnt_q     <= '0;
      slot_q         <= '0;
      cyc_q          <= '0;
      lfsr_q         <= 16'hACE1;
      replay_q       <= 1'b0;
      done_q         <= 1'b0;
      tx_hold_q      <= 1'b0;
      jam_q          <= 1'b0;
      drop_q         <= 1'b0;
      abort_late_q   <= 1'b0;
      abort_excess_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      attempts_q     <= attempts_d;
      late_q         <= late_d;
      jam_cnt_q      <= jam_cnt_d;
      tail_cnt_q     <= tail_cnt_d;
      slot_q         <= slot_d;
      cyc_q          <= cyc_d;
      lfsr_q         <= lfsr_d;
      replay_q       <= replay_d;
      done_q         <= done_d;
      tx_hold_q      <= tx_hold_d;
      jam_q          <= jam_d;
      drop_q         <= drop_d;
      abort_late_q   <= abort_late_d;
      abort_excess_q <= abort_excess_d;
    end
  end

  assign replay       = replay_q;
  assign done         = done_q;
  assign tx_hold      = tx_hold_q;
  assign jam          = jam_q;
  assign drop         = drop_q;
  assign abort_late   = abort_late_q;
  assign abort_excess = abort_excess_q;
  assign attempts     = attempts_q;

endmodule

// File: tb/tb_tx_collision_ctrl.sv
// tb/tb_tx_collision_ctrl.sv - randomized scenario bench for tx_collision_ctrl
// Expected timing comes from slot/jam/tail arithmetic and a free-running LFSR model.
module tb_tx_collision_ctrl;

  localparam int SLOT = 4;
  localparam int JAM  = 4;

  localparam logic [6:0] O_REPLAY = 7'b1000000;
  localparam logic [6:0] O_DONE   = 7'b0100000;
  localparam logic [6:0] O_HOLD   = 7'b0010000;
  localparam logic [6:0] O_JAM    = 7'b0001000;
  localparam logic [6:0] O_DROP   = 7'b0000100;
  localparam logic [6:0] O_LATE   = 7'b0000010;
  localparam logic [6:0] O_EXC    = 7'b0000001;

  logic       clk, rst, half_duplex, collision, pkt_start, pkt_end, replayable;
  logic       replay, done, tx_hold, jam, drop, abort_late, abort_excess;
  logic [4:0] attempts;
  logic [6:0] outs;

  int          checks, errors, exp_att, last_hold;
  logic [15:0] m_lfsr;

  tx_collision_ctrl #(
    .SLOT_CYCLES(SLOT), .JAM_CYCLES(JAM), .MAX_ATTEMPTS(16),
    .BACKOFF_LIMIT(10), .TAIL_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .half_duplex(half_duplex), .collision(collision),
    .pkt_start(pkt_start), .pkt_end(pkt_end), .replayable(replayable),
    .replay(replay), .done(done), .tx_hold(tx_hold), .jam(jam), .drop(drop),
    .abort_late(abort_late), .abort_excess(abort_excess), .attempts(attempts)
  );

  assign outs = {replay, done, tx_hold, jam, drop, abort_late, abort_excess};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : lfsr_step(m_lfsr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt();
    collision = 1'b0;
    pkt_end   = 1'b0;
    pkt_start = 1'b1;
    tick();
    pkt_start = 1'b0;
  endtask

  // Caller has collision (and replayable) set for the next edge; returns in IDLE or at the abort cycle.
  task automatic test_jam_backoff(input string tag);
    bit         late, bad;
    logic [6:0] e;
    int         k, r, want, cnt;
    late = !replayable;
    tick();
    collision = 1'b0;
    exp_att++;
    for (int j = 1; j <= JAM; j++) begin
      e = O_JAM | O_HOLD | ((j == 1 && !late) ? O_REPLAY : 7'b0);
      checks++;
      if (outs !== e || attempts !== 5'(exp_att)) begin
        errors++;
        $display("FAIL %s_jam%0d outs=%b att=%0d want outs=%b att=%0d", tag, j, outs, attempts, e, exp_att);
      end
      if (j < JAM) tick();
    end
    k    = (exp_att > 10) ? 10 : exp_att;
    r    = int'(m_lfsr) & ((1 << k) - 1);
    want = (r == 0) ? 1 : r * SLOT;
    tick();
    if (late || exp_att == 16) begin
      e = O_DONE | O_DROP | (late ? O_LATE : O_EXC);
      checks++;
      if (outs !== e || attempts !== 5'(exp_att)) begin
        errors++;
        $display("FAIL %s_abort outs=%b att=%0d want outs=%b att=%0d", tag, outs, attempts, e, exp_att);
      end
      last_hold = 0;
      return;
    end
    cnt = 0;
    bad = 1'b0;
    while (tx_hold === 1'b1 && cnt < 70000) begin
      if (outs !== O_HOLD || attempts !== 5'(exp_att)) bad = 1'b1;
      cnt++;
      tick();
    end
    checks++;
    if (cnt != want || bad) begin
      errors++;
      $display("FAIL %s_hold cycles=%0d bad=%0d want cycles=%0d bad=0", tag, cnt, bad, want);
    end
    checks++;
    if (outs !== 7'b0 || attempts !== 5'(exp_att)) begin
      errors++;
      $display("FAIL %s_idle outs=%b att=%0d want outs=0 att=%0d", tag, outs, attempts, exp_att);
    end
    last_hold = cnt;
  endtask

  task automatic test_drop_phase(input string tag);
    int n;
    bit bad;
    bad = 1'b0;
    n   = $urandom_range(1, 12);
    for (int i = 0; i < n; i++) begin
      collision  = 1'($urandom_range(0, 1));
      replayable = 1'($urandom_range(0, 1));
      tick();
      if (outs !== O_DROP || attempts !== 5'(exp_att)) bad = 1'b1;
    end
    collision = 1'b0;
    pkt_end   = 1'b1;
    tick();
    pkt_end    = 1'b0;
    replayable = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_drop level/attempts wrong during drain, want drop only att=%0d", tag, exp_att);
    end
    exp_att = 0;
    checks++;
    if (outs !== 7'b0 || attempts !== 5'd0) begin
      errors++;
      $display("FAIL %s_drop_end outs=%b att=%0d want outs=0 att=0", tag, outs, attempts);
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (outs !== 7'b0 || attempts !== 5'd0) begin
      errors++;
      $display("FAIL reset outs=%b att=%0d want outs=0 att=0", outs, attempts);
    end
    rst     = 1'b0;
    exp_att = 0;
    bad     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      half_duplex = 1'($urandom_range(0, 1));
      collision   = 1'($urandom_range(0, 1));
      pkt_end     = 1'($urandom_range(0, 1));
      tick();
      if (outs !== 7'b0 || attempts !== 5'd0) bad = 1'b1;
    end
    collision = 1'b0;
    pkt_end   = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_ignore outputs moved in IDLE, want all 0");
    end
  endtask

  task automatic test_full_duplex();
    int n;
    bit bad;
    half_duplex = 1'b0;
    replayable  = 1'b1;
    n   = $urandom_range(5, 40);
    bad = 1'b0;
    start_pkt();
    for (int b = 2; b <= n; b++) begin
      collision = (b == 10) || ($urandom_range(0, 3) == 0);
      pkt_end   = (b == n);
      tick();
      if (b < n && outs !== 7'b0) bad = 1'b1;
    end
    collision = 1'b0;
    pkt_end   = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fd_tx output asserted while collisions ignored, want all 0");
    end
    checks++;
    if (outs !== O_DONE || attempts !== 5'd0) begin
      errors++;
      $display("FAIL fd_done outs=%b att=%0d want outs=%b att=0", outs, attempts, O_DONE);
    end
    tick();
    checks++;
    if (outs !== 7'b0) begin
      errors++;
      $display("FAIL fd_after outs=%b want 0", outs);
    end
  endtask

  task automatic test_single_collision();
    int n;
    half_duplex = 1'b1;
    replayable  = 1'b1;
    start_pkt();
    for (int b = 2; b < 10; b++) tick();
    collision = 1'b1;
    test_jam_backoff("single");
    collision = 1'b1;
    pkt_end   = 1'b1;
    tick();
    collision = 1'b0;
    pkt_end   = 1'b0;
    checks++;
    if (outs !== 7'b0 || attempts !== 5'd1) begin
      errors++;
      $display("FAIL retain_idle outs=%b att=%0d want outs=0 att=1", outs, attempts);
    end
    start_pkt();
    half_duplex = 1'b0;
    n = $urandom_range(3, 20);
    for (int b = 2; b <= n; b++) begin
      collision = 1'($urandom_range(0, 1));
      pkt_end   = (b == n);
      tick();
    end
    collision = 1'b0;
    pkt_end   = 1'b0;
    exp_att   = 0;
    checks++;
    if (outs !== O_DONE || attempts !== 5'd0) begin
      errors++;
      $display("FAIL retry_done outs=%b att=%0d want outs=%b att=0", outs, attempts, O_DONE);
    end
    tick();
  endtask

  task automatic test_late();
    half_duplex = 1'b1;
    replayable  = 1'b1;
    start_pkt();
    repeat ($urandom_range(1, 8)) tick();
    replayable = 1'b0;
    collision  = 1'b1;
    test_jam_backoff("late");
    test_drop_phase("late");
  endtask

  task automatic test_tail();
    int  cnt, w;
    bit  bad;
    half_duplex = 1'b1;
    replayable  = 1'b1;
    start_pkt();
    for (int b = 2; b <= 20; b++) begin
      pkt_end = (b == 20);
      tick();
    end
    pkt_end = 1'b0;
    bad = 1'b0;
    for (int c = 1; c < 30; c++) begin
      if (outs !== 7'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL tail_quiet output asserted in tail window, want all 0");
    end
    collision = 1'b1;
    test_jam_backoff("tail");
    start_pkt();
    for (int b = 2; b <= 20; b++) begin
      pkt_end = (b == 20);
      tick();
    end
    pkt_end = 1'b0;
    cnt = 1;
    while (done !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    exp_att = 0;
    checks++;
    if (cnt != 64 || outs !== O_DONE || attempts !== 5'd0) begin
      errors++;
      $display("FAIL tail_expiry done_after=%0d outs=%b att=%0d want done_after=64 outs=%b att=0", cnt, outs, attempts, O_DONE);
    end
    start_pkt();
    pkt_end = 1'b1;
    tick();
    pkt_end = 1'b0;
    w = $urandom_range(0, 40);
    repeat (w) tick();
    replayable = 1'b0;
    tick();
    replayable = 1'b1;
    checks++;
    if (outs !== O_DONE || attempts !== 5'd0) begin
      errors++;
      $display("FAIL tail_release wait=%0d outs=%b att=%0d want outs=%b att=0", w, outs, attempts, O_DONE);
    end
    tick();
  endtask

  task automatic test_excessive();
    int maxh;
    half_duplex = 1'b1;
    replayable  = 1'b1;
    maxh = 0;
    for (int a = 1; a <= 16; a++) begin
      start_pkt();
      repeat ($urandom_range(0, 5)) tick();
      collision = 1'b1;
      test_jam_backoff("excess");
      if (last_hold > maxh) maxh = last_hold;
    end
    checks++;
    if (maxh > 1023 * SLOT) begin
      errors++;
      $display("FAIL excess_backoff_bound max_hold=%0d want <= %0d", maxh, 1023 * SLOT);
    end
    test_drop_phase("excess");
  endtask

  task automatic test_reset_backoff();
    int k, r;
    bit hit;
    half_duplex = 1'b1;
    replayable  = 1'b1;
    hit = 1'b0;
    for (int a = 0; a < 12 && !hit; a++) begin
      start_pkt();
      collision = 1'b1;
      tick();
      collision = 1'b0;
      exp_att++;
      repeat (JAM - 1) tick();
      k = (exp_att > 10) ? 10 : exp_att;
      r = int'(m_lfsr) & ((1 << k) - 1);
      tick();
      if (r > 0) begin
        repeat ($urandom_range(0, (r * SLOT - 2 > 50) ? 50 : r * SLOT - 2)) tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        hit     = 1'b1;
        exp_att = 0;
        checks++;
        if (outs !== 7'b0 || attempts !== 5'd0) begin
          errors++;
          $display("FAIL rst_backoff outs=%b att=%0d want outs=0 att=0", outs, attempts);
        end
      end else begin
        tick();
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_backoff_reach got no multi-cycle backoff in 12 attempts, want one");
    end
    start_pkt();
    collision = 1'b1;
    test_jam_backoff("post_rst");
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_att     = 0;
    last_hold   = 0;
    rst         = 1'b1;
    half_duplex = 1'b0;
    collision   = 1'b0;
    pkt_start   = 1'b0;
    pkt_end     = 1'b0;
    replayable  = 1'b1;
    test_reset();
    test_full_duplex();
    test_single_collision();
    test_late();
    test_tail();
    test_excessive();
    test_reset_backoff();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
